// File: rtl/pwm_pkg.sv
// Shared constants for the PWM period/duty timebase.
package pwm_pkg;

    localparam int PWM_N_DEFAULT     = 7;
    localparam int PWM_PSC_W_DEFAULT = 8;

    // Reset constants are kept wide and sliced to N by the users.
    localparam logic [31:0] PWM_TOP_ACT_RST  = '1;
    localparam logic [31:0] PWM_DUTY_ACT_RST = '0;

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// Clock-enable prescaler: one tick every psc+1 enabled cycles, psc sampled live.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PSC_W = PWM_PSC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] psc_cnt_q;
    logic [PSC_W-1:0] psc_cnt_d;

    // >= rather than == so lowering psc below the count ticks immediately.
    always_comb begin
        tick      = 1'b0;
        psc_cnt_d = psc_cnt_q;
        if (en) begin
            if (psc_cnt_q >= psc) begin
                tick      = 1'b1;
                psc_cnt_d = '0;
            end else begin
                psc_cnt_d = psc_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end

endmodule : pwm_prescaler

// File: rtl/pwm_period_counter.sv
// PWM period counter with a one-deep pending {top, duty} slot applied at wrap.
// Optional prescaler compiled in with `define PWM_PRESCALER_EN.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int N     = PWM_N_DEFAULT,
    parameter int PSC_W = PWM_PSC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [N-1:0]     cfg_top,
    input  logic [N-1:0]     cfg_duty,
`ifdef PWM_PRESCALER_EN
    input  logic [PSC_W-1:0] psc,
`endif
    output logic [N-1:0]     cnt,
    output logic [N-1:0]     duty_act,
    output logic [N-1:0]     top_act,
    output logic             period_end
);

    if (N < 1 || PSC_W < 1) begin : g_bad_param
        $error("pwm_period_counter: N and PSC_W must be at least 1");
    end

    logic tick;

`ifdef PWM_PRESCALER_EN
    pwm_prescaler #(
        .PSC_W (PSC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .psc   (psc),
        .tick  (tick)
    );
`else
    assign tick = en;
`endif

    logic [N-1:0] cnt_q,        cnt_d;
    logic [N-1:0] top_act_q,    top_act_d;
    logic [N-1:0] duty_act_q,   duty_act_d;
    logic         period_end_q, period_end_d;
    logic         pending_q,    pending_d;
    logic [N-1:0] pend_top_q,   pend_top_d;
    logic [N-1:0] pend_duty_q,  pend_duty_d;

    logic wrap;
    logic accept;
    logic apply;

    assign wrap      = tick && (cnt_q == top_act_q);
    assign cfg_ready = !pending_q;
    assign accept    = cfg_valid && !pending_q;
    assign apply     = wrap && pending_q;

    // accept and apply are mutually exclusive: one needs pending low, the other high.
    always_comb begin
        cnt_d        = cnt_q;
        top_act_d    = top_act_q;
        duty_act_d   = duty_act_q;
        pending_d    = pending_q;
        pend_top_d   = pend_top_q;
        pend_duty_d  = pend_duty_q;
        period_end_d = wrap;

        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end

        if (apply) begin
            top_act_d  = pend_top_q;
            duty_act_d = pend_duty_q;
            pending_d  = 1'b0;
        end else if (accept) begin
            pend_top_d  = cfg_top;
            pend_duty_d = cfg_duty;
            pending_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            top_act_q    <= PWM_TOP_ACT_RST[N-1:0];
            duty_act_q   <= PWM_DUTY_ACT_RST[N-1:0];
            period_end_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            top_act_q    <= top_act_d;
            duty_act_q   <= duty_act_d;
            period_end_q <= period_end_d;
            pending_q    <= pending_d;
        end
    end

    // Pending data is only ever read while pending_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_top_q  <= pend_top_d;
        pend_duty_q <= pend_duty_d;
    end

    assign cnt        = cnt_q;
    assign duty_act   = duty_act_q;
    assign top_act    = top_act_q;
    assign period_end = period_end_q;

endmodule : pwm_period_counter
